pp_column_loader: RTL and testbench
===================================

// Module: pp_column_loader
// PURPOSE
//  Upstream feeder for the cascade mul17 shift_register/compressor pair.
//  Accepts one unsigned operand pair (a, b) per transaction over a valid/ready handshake.
//  Streams the partial-product bit a[i]&b[j] of each column k=i+j serially onto src<k>_,
//  one bit per column per clock, over N cycles, so the column shift registers then hold
//  the complete partial-product array.
//  Pulses result_valid on the single cycle in which compressor outputs dst0..dst(2N-1)
//  equal a*b. The shift registers have no enable, so the result is valid for one cycle only.
// PARAMETERS
//  N  17  operand width; drives 2N-1 column outputs and the column depths d_k=min(k+1, 2N-1-k)
// PORTS
//  clk            input   1    clock; all state updates on posedge
//  rst            input   1    reset, synchronous, active-high
//  in_valid       input   1    operand pair offered
//  in_ready       output  1    loader can accept a pair (state IDLE)
//  a              input   N    multiplicand, unsigned
//  b              input   N    multiplier, unsigned
//  src0_..src(2N-2)_  output  1 each  serial column bits into the shift_register inputs
//  result_valid   output  1    one-cycle pulse; dst bus of compressor equals a*b this cycle
//  busy           output  1    high in LOAD or DONE
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset (rst=1 at posedge): state=IDLE, cnt=0, a_q=b_q=0.
//   After reset: in_ready=1, result_valid=0, busy=0, all src*_ = 0.
//  States:
//   IDLE  in_ready=1; in_valid&in_ready at posedge -> latch a_q=a, b_q=b, cnt=0, go to LOAD.
//   LOAD  in_ready=0; cnt counts 0..N-1; at posedge with cnt==N-1 -> DONE, else cnt+1.
//   DONE  result_valid=1 for exactly this cycle; in_ready=0; at next posedge -> IDLE.
//  in_valid is ignored while in_ready=0; a/b are not sampled outside the accepting edge.
//  Column emission is combinational from state, cnt, a_q and b_q; registered state only.
//   In LOAD, for column k (0..2N-2), with jmin=max(0, k-N+1) and s_k=N-d_k:
//   - cnt <  s_k: src<k>_ = 0 (shifted out of the shallower register before DONE).
//   - cnt >= s_k: j = jmin + (cnt - s_k), i = k - j, src<k>_ = a_q[i] & b_q[j].
//   In IDLE and DONE: all src<k>_ = 0.
//  Latency: acceptance edge E0 -> LOAD for N cycles -> result_valid high in cycle N+1 after E0.
//  Throughput: one product per N+2 cycles.
//  Width: a*b fits 2N bits; the compressor's top output (dst2N-1) carries the final carry.
//   No saturation or sign handling.
//  Reset mid-LOAD or in DONE: abort to IDLE; no result_valid for the aborted pair.
//   Shift-register contents are undefined after an abort; consumers use dst only when
//   result_valid=1.
//  Simultaneous rst and in_valid: rst wins; the pair is not accepted.
// TESTING
//  1. a=0x1FFFF, b=0x1FFFF accepted at E0 -> result_valid exactly at cycle E0+18;
//     {dst33..dst0} = 34'h3FFFC0001.
//  2. a=1, b=1 -> src0_=1 only during cnt=16; every other src*_ stays 0 all of LOAD;
//     result on dst = 1.
//  3. a=3, b=5, then a=0, b=0x1ABCD with in_valid held high:
//     in_ready=0 throughout LOAD/DONE; second pair accepted in the first IDLE cycle;
//     results 15 then 0.
//  4. rst=1 at cnt=7 of LOAD -> next cycle IDLE, in_ready=1, no result_valid pulse;
//     next pair a=0x12345, b=0x00FF0 gives 0x12345*0x00FF0 at its result_valid.
//  5. in_valid and rst high on the same edge -> no acceptance; busy stays 0.
//  6. Random a, b, 1000 pairs with random in_valid gaps -> dst equals a*b at every
//     result_valid, and result_valid never fires without a prior acceptance.

Source files
------------

// File: rtl/pp_column_loader.sv
// Serial partial-product feeder for the cascade mul17 column shift registers.
// Latches one operand pair, then streams every a[i]&b[j] bit onto its column k=i+j over N cycles.
module pp_column_loader #(
  parameter int N = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         src0_,
  output logic         src1_,
  output logic         src2_,
  output logic         src3_,
  output logic         src4_,
  output logic         src5_,
  output logic         src6_,
  output logic         src7_,
  output logic         src8_,
  output logic         src9_,
  output logic         src10_,
  output logic         src11_,
  output logic         src12_,
  output logic         src13_,
  output logic         src14_,
  output logic         src15_,
  output logic         src16_,
  output logic         src17_,
  output logic         src18_,
  output logic         src19_,
  output logic         src20_,
  output logic         src21_,
  output logic         src22_,
  output logic         src23_,
  output logic         src24_,
  output logic         src25_,
  output logic         src26_,
  output logic         src27_,
  output logic         src28_,
  output logic         src29_,
  output logic         src30_,
  output logic         src31_,
  output logic         src32_,
  output logic         result_valid,
  output logic         busy
);

  localparam int CW     = $clog2(N);
  localparam int NCOL   = 2 * N - 1;
  localparam int MAXCOL = 33;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [MAXCOL-1:0] col;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            cnt      <= '0;
            state    <= LOAD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (cnt == CW'(N - 1)) begin
            state        <= DONE;
            result_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
          in_ready     <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
          in_ready     <= 1'b1;
        end
      endcase
    end
  end

  // Column k emits its d_k bits in the last d_k LOAD cycles so earlier (zero) bits
  // are shifted out of the depth-d_k register before DONE.
  for (genvar k = 0; k < MAXCOL; k++) begin : g_col
    if (k < NCOL) begin : g_live
      localparam int D    = (k + 1 < NCOL - k) ? k + 1 : NCOL - k;
      localparam int S    = N - D;
      localparam int JMIN = (k > N - 1) ? k - N + 1 : 0;
      logic [CW-1:0] j;
      logic [CW-1:0] i;
      logic          act;
      if (S == 0) begin : g_full
        assign act = 1'b1;
      end else begin : g_late
        assign act = (cnt >= CW'(S));
      end
      // Modulo-2^CW arithmetic is exact here because the true i and j lie in 0..N-1.
      assign j      = CW'(JMIN) + (cnt - CW'(S));
      assign i      = CW'(k) - j;
      assign col[k] = (state == LOAD) && act && a_q[i] && b_q[j];
    end else begin : g_none
      assign col[k] = 1'b0;
    end
  end

  assign {src32_, src31_, src30_, src29_, src28_, src27_, src26_, src25_, src24_,
          src23_, src22_, src21_, src20_, src19_, src18_, src17_, src16_, src15_,
          src14_, src13_, src12_, src11_, src10_, src9_,  src8_,  src7_,  src6_,
          src5_,  src4_,  src3_,  src2_,  src1_,  src0_} = col;

endmodule

// File: tb/tb_pp_column_loader.sv
// Bench for pp_column_loader: models the column shift registers and compressor sum,
// and scoreboards the product expected at each result_valid pulse.
module tb_pp_column_loader;

  localparam int N    = 17;
  localparam int NCOL = 2 * N - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] a;
  logic [16:0] b;
  logic        result_valid;
  logic        busy;
  logic src0_,  src1_,  src2_,  src3_,  src4_,  src5_,  src6_,  src7_,  src8_;
  logic src9_,  src10_, src11_, src12_, src13_, src14_, src15_, src16_, src17_;
  logic src18_, src19_, src20_, src21_, src22_, src23_, src24_, src25_, src26_;
  logic src27_, src28_, src29_, src30_, src31_, src32_;
  logic [32:0] src_v;

  always #5 clk = ~clk;

  pp_column_loader #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .src0_(src0_),   .src1_(src1_),   .src2_(src2_),   .src3_(src3_),   .src4_(src4_),
    .src5_(src5_),   .src6_(src6_),   .src7_(src7_),   .src8_(src8_),   .src9_(src9_),
    .src10_(src10_), .src11_(src11_), .src12_(src12_), .src13_(src13_), .src14_(src14_),
    .src15_(src15_), .src16_(src16_), .src17_(src17_), .src18_(src18_), .src19_(src19_),
    .src20_(src20_), .src21_(src21_), .src22_(src22_), .src23_(src23_), .src24_(src24_),
    .src25_(src25_), .src26_(src26_), .src27_(src27_), .src28_(src28_), .src29_(src29_),
    .src30_(src30_), .src31_(src31_), .src32_(src32_),
    .result_valid(result_valid), .busy(busy)
  );

  assign src_v = {src32_, src31_, src30_, src29_, src28_, src27_, src26_, src25_, src24_,
                  src23_, src22_, src21_, src20_, src19_, src18_, src17_, src16_, src15_,
                  src14_, src13_, src12_, src11_, src10_, src9_,  src8_,  src7_,  src6_,
                  src5_,  src4_,  src3_,  src2_,  src1_,  src0_};

  typedef struct {
    logic [33:0] exp;
    int          acc_edge;
  } sb_t;

  sb_t         sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_cnt = 0;
  logic [16:0] sr [NCOL];

  function automatic int depth(int k);
    return (k + 1 < NCOL - k) ? k + 1 : NCOL - k;
  endfunction

  // Compressor output: each column contributes popcount(register) * 2^k.
  function automatic logic [33:0] dst_model();
    logic [33:0] s = '0;
    for (int k = 0; k < NCOL; k++)
      for (int t = 0; t < depth(k); t++)
        s = s + (34'(sr[k][t]) << k);
    return s;
  endfunction

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    for (int k = 0; k < NCOL; k++) sr[k] <= {sr[k][15:0], src_v[k]};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every result_valid pulse must match the oldest outstanding acceptance.
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_result_valid: got pulse, expected none at t=%0t", $time);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("dst_product", 64'(dst_model()), 64'(e.exp));
        chk("latency", 64'(edge_cnt - e.acc_edge), 64'(N));
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [16:0] av, input logic [16:0] bv,
                      input logic [33:0] exp, input bit hold);
    int w = 0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      sb.push_back('{exp: exp, acc_edge: edge_cnt + 1});
    end
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_outstanding", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_src", 64'(src_v), 64'd0);

    // All-ones operands: largest product, carry into the top bit.
    send(17'h1FFFF, 17'h1FFFF, 34'h3FFFC0001, 1'b0);
    chk("load_busy", 64'(busy), 64'd1);
    drain();

    // 1*1: only column 0 fires, and only in the last LOAD cycle.
    send(17'd1, 17'd1, 34'd1, 1'b0);
    for (int c = 0; c < N; c++) begin
      chk("one_one_src", 64'(src_v), (c == N - 1) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
    drain();

    // Back-to-back with in_valid held: second pair waits for IDLE.
    send(17'd3, 17'd5, 34'd15, 1'b1);
    a = 17'd0;
    b = 17'h1ABCD;
    for (int c = 0; c < N + 1; c++) begin
      chk("held_in_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    chk("held_in_ready_idle", 64'(in_ready), 64'd1);
    send(17'd0, 17'h1ABCD, 34'd0, 1'b0);
    drain();

    // Abort at cnt=7: the pending product must never be reported.
    send(17'h0F0F0, 17'h13579, 34'(17'h0F0F0) * 34'(17'h13579), 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (N + 3) @(negedge clk);
    send(17'h12345, 17'h00FF0, 34'h12221BB0, 1'b0);
    drain();

    // rst and in_valid on the same edge: no acceptance.
    a = 17'h1234;
    b = 17'h0777;
    in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_vs_valid_busy", 64'(busy), 64'd0);
    chk("rst_vs_valid_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("rst_vs_valid_busy2", 64'(busy), 64'd0);

    for (int p = 0; p < 1000; p++) begin
      ra = 17'($urandom);
      rb = 17'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(ra, rb, 34'(ra) * 34'(rb), 1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
